vga_timing_generator: RTL and testbench

VGA_TIMING_GENERATOR -- requirements
Module: vga_timing_generator

---
 rtl/vga_timing_generator.sv | 155 +++++++++++++++
 tb/tb_vga_timing_generator.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_generator.sv
// VGA raster timing: x/y counters, registered syncs, visible and frame_start flags.
// Optional line_req prefetch output is built when VGA_TIMING_LINE_REQ_EN is defined.
module vga_timing_generator #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned SYNC_POL  = 0
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start
`ifdef VGA_TIMING_LINE_REQ_EN
  ,
  output logic       line_req
`endif
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024) begin : g_h_total_err
    $error("vga_timing_generator: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_v_total_err
    $error("vga_timing_generator: V_TOTAL exceeds 1024");
  end

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEG   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic        SYNC_ACT = (SYNC_POL != 0);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [9:0]  w_nx;
  logic [9:0]  w_ny;
  logic [10:0] w_nx11;
  logic [10:0] w_ny11;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_visible;
  logic        r_frame_start;
  logic        w_hsync_nxt;
  logic        w_vsync_nxt;
  logic        w_visible_nxt;
  logic        w_frame_start_nxt;
`ifdef VGA_TIMING_LINE_REQ_EN
  logic        r_line_req;
  logic        w_line_req_nxt;
`endif

  // Next position; the first strobe out of IDLE lands on (0,0) without stepping.
  always_comb begin
    w_state_nxt = r_state;
    w_nx        = r_x;
    w_ny        = r_y;
    case (r_state)
      S_IDLE: begin
        if (pix_en) begin
          w_state_nxt = S_RUN;
          w_nx        = '0;
          w_ny        = '0;
        end
      end
      S_RUN: begin
        if (pix_en) begin
          if (r_x == H_LAST) begin
            w_nx = '0;
            w_ny = (r_y == V_LAST) ? '0 : r_y + 10'd1;
          end else begin
            w_nx = r_x + 10'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_nx        = '0;
        w_ny        = '0;
      end
    endcase
  end

  // Flags decode the upcoming position so they register in step with x/y.
  always_comb begin
    w_nx11            = {1'b0, w_nx};
    w_ny11            = {1'b0, w_ny};
    w_hsync_nxt       = ((w_nx11 >= HS_BEG) && (w_nx11 < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
    w_vsync_nxt       = ((w_ny11 >= VS_BEG) && (w_ny11 < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
    w_visible_nxt     = (w_nx11 < H_VIS) && (w_ny11 < V_VIS);
    w_frame_start_nxt = (w_nx == '0) && (w_ny == '0);
`ifdef VGA_TIMING_LINE_REQ_EN
    w_line_req_nxt    = (w_nx11 == H_VIS) && ((w_ny == V_LAST) || (w_ny11 + 11'd1 < V_VIS));
`endif
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_x           <= '0;
      r_y           <= '0;
      r_hsync       <= ~SYNC_ACT;
      r_vsync       <= ~SYNC_ACT;
      r_visible     <= 1'b0;
      r_frame_start <= 1'b0;
`ifdef VGA_TIMING_LINE_REQ_EN
      r_line_req    <= 1'b0;
`endif
    end else if (pix_en) begin
      r_state       <= w_state_nxt;
      r_x           <= w_nx;
      r_y           <= w_ny;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_visible     <= w_visible_nxt;
      r_frame_start <= w_frame_start_nxt;
`ifdef VGA_TIMING_LINE_REQ_EN
      r_line_req    <= w_line_req_nxt;
`endif
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign visible     = r_visible;
  assign frame_start = r_frame_start;
`ifdef VGA_TIMING_LINE_REQ_EN
  assign line_req    = r_line_req;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench: default-timing instance for line checks, small SYNC_POL=1 instance for frame checks.
// Builds the line_req checks when VGA_TIMING_LINE_REQ_EN is defined.
module tb_vga_timing_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       pe;
  logic       d_hs, d_vs, d_vis, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_hs, s_vs, s_vis, s_fs;
  logic [9:0] s_x, s_y;
`ifdef VGA_TIMING_LINE_REQ_EN
  logic       d_lr, s_lr;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_timing_generator dut (
    .clkin(clk), .reset(rst), .pix_en(pe),
    .hsync(d_hs), .vsync(d_vs), .visible(d_vis),
    .x(d_x), .y(d_y), .frame_start(d_fs)
`ifdef VGA_TIMING_LINE_REQ_EN
    , .line_req(d_lr)
`endif
  );

  // 24 pixels x 15 lines, active-high syncs: hsync x=18..21, vsync y=10..11.
  vga_timing_generator #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_VISIBLE(8),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .SYNC_POL(1)
  ) dut_s (
    .clkin(clk), .reset(rst), .pix_en(pe),
    .hsync(s_hs), .vsync(s_vs), .visible(s_vis),
    .x(s_x), .y(s_y), .frame_start(s_fs)
`ifdef VGA_TIMING_LINE_REQ_EN
    , .line_req(s_lr)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int d_bad, s_bad, falls, first_fall_x, first_fall_y, fall1, fall2, low_run;
    int s_vs_min, s_vs_max, s_fs_cnt, hold_bad, hs_low;
    logic prev_hs;
    logic [9:0] sx0, sy0;
    logic [25:0] snap;
`ifdef VGA_TIMING_LINE_REQ_EN
    int d_lr_first, s_lr_cnt, s_lr_y14_x;
`endif

    rst = 1'b1;
    pe  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_d_x", d_x, 0);
    chk("rst_d_y", d_y, 0);
    chk("rst_d_vis", d_vis, 0);
    chk("rst_d_fs", d_fs, 0);
    chk("rst_d_hs", d_hs, 1);
    chk("rst_d_vs", d_vs, 1);
    chk("rst_s_hs", s_hs, 0);
    chk("rst_s_vs", s_vs, 0);

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_d_x", d_x, 0);
    chk("idle_d_vis", d_vis, 0);
    chk("idle_d_fs", d_fs, 0);

    pe = 1'b1;
    @(negedge clk);
    chk("first_d_x", d_x, 0);
    chk("first_d_y", d_y, 0);
    chk("first_d_fs", d_fs, 1);
    chk("first_d_vis", d_vis, 1);
    chk("first_d_hs", d_hs, 1);
    chk("first_s_fs", s_fs, 1);
    chk("first_s_hs", s_hs, 0);

    // Continuous strobe: 3 default lines, ~6.7 small frames.
    d_bad = 0; s_bad = 0; falls = 0; first_fall_x = -1; first_fall_y = -1;
    fall1 = -1; fall2 = -1; low_run = 0; prev_hs = d_hs;
    s_vs_min = 1000; s_vs_max = -1; s_fs_cnt = 0;
`ifdef VGA_TIMING_LINE_REQ_EN
    d_lr_first = -1; s_lr_cnt = 0; s_lr_y14_x = -1;
`endif
    for (int step = 1; step <= 2400; step++) begin
      int ex, ey, sx, sy;
      @(negedge clk);
      ex = step % 800;  ey = step / 800;
      sx = step % 24;   sy = (step / 24) % 15;
      if (d_x !== 10'(ex) || d_y !== 10'(ey)) d_bad++;
      if (d_hs !== ((ex >= 656 && ex < 752) ? 1'b0 : 1'b1)) d_bad++;
      if (d_vs !== 1'b1) d_bad++;
      if (d_vis !== (ex < 640 && ey < 480)) d_bad++;
      if (d_fs !== (ex == 0 && ey == 0)) d_bad++;
      if (s_x !== 10'(sx) || s_y !== 10'(sy)) s_bad++;
      if (s_hs !== ((sx >= 18 && sx < 22) ? 1'b1 : 1'b0)) s_bad++;
      if (s_vis !== (sx < 16 && sy < 8)) s_bad++;
      if (prev_hs === 1'b1 && d_hs === 1'b0) begin
        falls++;
        if (falls == 1) begin first_fall_x = int'(d_x); first_fall_y = int'(d_y); fall1 = step; end
        if (falls == 2) fall2 = step;
      end
      if (step < 800 && d_hs === 1'b0) low_run++;
      prev_hs = d_hs;
      if (s_vs === 1'b1) begin
        if (int'(s_y) < s_vs_min) s_vs_min = int'(s_y);
        if (int'(s_y) > s_vs_max) s_vs_max = int'(s_y);
      end
      if (s_fs === 1'b1) s_fs_cnt++;
      if (step == 359) begin
        chk("s_last_x", s_x, 23);
        chk("s_last_y", s_y, 14);
      end
      if (step == 360) begin
        chk("s_wrap_x", s_x, 0);
        chk("s_wrap_y", s_y, 0);
        chk("s_wrap_fs", s_fs, 1);
        chk("s_wrap_vis", s_vis, 1);
        chk("s_wrap_vs", s_vs, 0);
      end
`ifdef VGA_TIMING_LINE_REQ_EN
      if (d_lr === 1'b1 && d_lr_first < 0) d_lr_first = step;
      if (step >= 360 && step < 720 && s_lr === 1'b1) s_lr_cnt++;
      if (s_lr === 1'b1 && s_y == 10'd14 && s_lr_y14_x < 0) s_lr_y14_x = int'(s_x);
`endif
    end
    chk("d_track", d_bad, 0);
    chk("s_track", s_bad, 0);
    chk("hs_fall_x", first_fall_x, 656);
    chk("hs_fall_y", first_fall_y, 0);
    chk("hs_low_len", low_run, 96);
    chk("hs_period", fall2 - fall1, 800);
    chk("hs_falls", falls, 3);
    chk("s_vs_ymin", s_vs_min, 10);
    chk("s_vs_ymax", s_vs_max, 11);
    chk("s_fs_count", s_fs_cnt, 6);
    chk("end_d_y", d_y, 3);
`ifdef VGA_TIMING_LINE_REQ_EN
    chk("d_lr_first", d_lr_first, 640);
    chk("s_lr_per_frame", s_lr_cnt, 8);
    chk("s_lr_y14_x", s_lr_y14_x, 16);
`endif

    // Strobe every 4th clock: one line of the default timing = 3200 clocks.
    hold_bad = 0; hs_low = 0;
    for (int c = 0; c < 3200; c++) begin
      pe = (c % 4 == 0);
      snap = {d_x, d_y, d_hs, d_vs, d_vis, d_fs, s_hs, s_vs};
      @(negedge clk);
      if (!pe && snap !== {d_x, d_y, d_hs, d_vs, d_vis, d_fs, s_hs, s_vs}) hold_bad++;
      if (d_hs === 1'b0) hs_low++;
    end
    chk("div4_hold", hold_bad, 0);
    chk("div4_x", d_x, 0);
    chk("div4_y", d_y, 4);
    chk("div4_hs_low", hs_low, 384);

    // Asynchronous reset between edges, mid-frame.
    pe = 1'b1;
    @(negedge clk);
    sx0 = s_x; sy0 = s_y;
    chk("pre_rst_moving", (sx0 != 10'd0 || sy0 != 10'd0) ? 1 : 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_d_y", d_y, 0);
    chk("arst_d_x", d_x, 0);
    chk("arst_d_vis", d_vis, 0);
    chk("arst_s_x", s_x, 0);
    chk("arst_s_y", s_y, 0);
    chk("arst_s_hs", s_hs, 0);
    chk("arst_s_vs", s_vs, 0);
    chk("arst_s_fs", s_fs, 0);
    @(negedge clk);
    pe  = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_idle_vis", d_vis, 0);
    pe = 1'b1;
    @(negedge clk);
    chk("restart_x", d_x, 0);
    chk("restart_y", d_y, 0);
    chk("restart_fs", d_fs, 1);
    @(negedge clk);
    chk("restart_x1", d_x, 1);
    chk("restart_fs1", d_fs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
